// File: rtl/unidad_logica_segmentada.sv
// Purpose  : ANCHO-bit bitwise logic unit (8 ops) with accumulate mode and zero/parity flags.
// Latency  : 2 cycles input transfer -> salida_valido; 1 beat/cycle sustained.
// Backpress: valid/ready on both sides; entrada_listo = !v1 | !v2 | salida_listo (bubbles collapse).
//
// Ports: reloj/reset_n (async active-low); entrada_* operand beat (A, B, operacion, acumular)
//        with valido/listo; salida_* result beat with cero/paridad flags; contador_ops counts
//        output transfers (saturating) when UNIDAD_LOGICA_CONTADOR_EN is defined, else const 0.
module unidad_logica_segmentada #(
    parameter int ANCHO      = 8,
    parameter int ANCHO_CONT = 16
) (
    input  logic                  reloj,
    input  logic                  reset_n,
    input  logic                  entrada_valido,
    output logic                  entrada_listo,
    input  logic [ANCHO-1:0]      entrada_A,
    input  logic [ANCHO-1:0]      entrada_B,
    input  logic [2:0]            operacion,
    input  logic                  acumular,
    output logic                  salida_valido,
    input  logic                  salida_listo,
    output logic [ANCHO-1:0]      salida,
    output logic                  salida_cero,
    output logic                  salida_paridad,
    output logic [ANCHO_CONT-1:0] contador_ops
);

    // Stage 1 operand registers
    logic             v1;
    logic [ANCHO-1:0] a_s1;
    logic [ANCHO-1:0] b_s1;
    logic [2:0]       op_s1;
    logic             acum_s1;

    // Stage 2 / result state
    logic             v2;
    logic [ANCHO-1:0] acumulador;

    logic             avance1;
    logic             avance2;
    logic [ANCHO-1:0] operando_b;
    logic [ANCHO-1:0] resultado;

    assign avance2       = !v2 || salida_listo;
    assign avance1       = !v1 || avance2;
    assign entrada_listo = avance1;
    assign salida_valido = v2;

    // The accumulator always holds the result of the previous beat in order: a beat is
    // computed only as it moves into stage 2, by which time its predecessor is already done.
    always_comb begin
        operando_b = acum_s1 ? acumulador : b_s1;
        resultado  = a_s1;
        case (op_s1)
            3'b000:  resultado = ~a_s1;
            3'b001:  resultado = a_s1 & operando_b;
            3'b010:  resultado = a_s1 | operando_b;
            3'b011:  resultado = a_s1 ^ operando_b;
            3'b100:  resultado = ~(a_s1 & operando_b);
            3'b101:  resultado = ~(a_s1 | operando_b);
            3'b110:  resultado = ~(a_s1 ^ operando_b);
            default: resultado = a_s1;
        endcase
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            v1             <= 1'b0;
            a_s1           <= '0;
            b_s1           <= '0;
            op_s1          <= '0;
            acum_s1        <= 1'b0;
            v2             <= 1'b0;
            salida         <= '0;
            salida_cero    <= 1'b1;
            salida_paridad <= 1'b0;
            acumulador     <= '0;
        end else begin
            if (avance1) begin
                v1 <= entrada_valido;
                // Operands only captured on a real beat so idle cycles leave them untouched.
                if (entrada_valido) begin
                    a_s1    <= entrada_A;
                    b_s1    <= entrada_B;
                    op_s1   <= operacion;
                    acum_s1 <= acumular;
                end
            end
            if (avance2) begin
                v2 <= v1;
                // Bubbles leave result and flags holding their last values.
                if (v1) begin
                    salida         <= resultado;
                    salida_cero    <= (resultado == '0);
                    salida_paridad <= ^resultado;
                    acumulador     <= resultado;
                end
            end
        end
    end

`ifdef UNIDAD_LOGICA_CONTADOR_EN
    logic [ANCHO_CONT-1:0] cuenta;

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            cuenta <= '0;
        end else if (salida_valido && salida_listo && (cuenta != '1)) begin
            cuenta <= cuenta + {{(ANCHO_CONT-1){1'b0}}, 1'b1};
        end
    end

    assign contador_ops = cuenta;
`else
    assign contador_ops = '0;
`endif

endmodule

// File: doc/unidad_logica_segmentada.md
Name: unidad_logica_segmentada

Overview:
- Parametrised successor to the team's single-bit combinational gate block.
- Applies one of eight bitwise logic operations (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS) to ANCHO-bit operands through a 2-stage pipeline with valid/ready handshakes on both sides.
- Adds an accumulate mode (operand B replaced by the last computed result) and zero/parity flags.
- Intended as the first sequential, cocotb-verified datapath block built on the gate set.

Parameters:
ANCHO, 8, operand/result width in bits (legal 1..64)
ANCHO_CONT, 16, width of optional operation counter (legal 4..32)

Ports:
reloj  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
entrada_valido  input  1  operand beat valid
entrada_listo  output  1  block can accept operand beat
entrada_A  input  ANCHO  operand A
entrada_B  input  ANCHO  operand B (ignored when acumular=1)
operacion  input  3  operation select
acumular  input  1  use accumulator in place of B
salida_valido  output  1  result beat valid
salida_listo  input  1  downstream accepts result
salida  output  ANCHO  result
salida_cero  output  1  result == 0
salida_paridad  output  1  XOR-reduction of result
contador_ops  output  ANCHO_CONT  completed-operation count (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous): v1=0, v2=0, salida=0, salida_cero=1, salida_paridad=0, accumulator=0, contador_ops=0. Reset mid-operation discards all in-flight beats; no partial output after release.
- Opcodes: 000 ~A; 001 A&B; 010 A|B; 011 A^B; 100 ~(A&B); 101 ~(A|B); 110 ~(A^B); 111 A (pass). All bitwise over ANCHO bits; no carries, no width growth.
- Transfer rules: input beat transfers when entrada_valido & entrada_listo; output beat transfers when salida_valido & salida_listo.
- Stage 1: registers A, B, operacion, acumular, and v1 on input transfer.
- Stage 2: computes the result from stage-1 contents and registers salida, flags and v2.
- Advance logic:
  - avance2 = !v2 | salida_listo
  - avance1 = !v1 | avance2
  - entrada_listo = avance1 (combinational from salida_listo; bubbles collapse)
- Stage 1 loads when avance1. v1 <= entrada_valido on that edge.
- Stage 2 loads when avance2. v2 <= v1 on that edge.
- Latency: 2 cycles from input transfer to salida_valido with no backpressure. Throughput: 1 beat/cycle.
- Accumulator:
  - Updated to the computed result whenever stage 2 loads with v1=1.
  - When acumular=1 in stage 1, operand B = accumulator. This is always the result of the immediately preceding operation in order; no hazard, since computation occurs only at stage 2.
- Backpressure: while v2=1 and salida_listo=0, salida, flags, stage 2 and the accumulator hold stable. Stage 1 also holds if v1=1. Input beats are never dropped or duplicated.
- salida_cero and salida_paridad are registered with salida and valid whenever salida_valido=1. They hold their last values when v2=0.
- Simultaneous output transfer and stage-1 load in the same cycle is legal. Full pipeline with salida_listo=1 streams one beat per cycle.
- Operands are never X-propagated when valid=0: stage registers simply hold.

Optional Feature:
UNIDAD_LOGICA_CONTADOR_EN
- Defined:
  - contador_ops increments by 1 on every output transfer.
  - Saturates at 2^ANCHO_CONT-1 (no wrap).
  - Cleared only by reset.
- Undefined: contador_ops is constant 0 and no counter flops are synthesised. The port always exists so the bench has a single interface.

Test Plan:
1. ANCHO=8, salida_listo=1; send A=0xA5, B=0x0F with each opcode 000..111 on consecutive cycles -> outputs 0x5A,0x05,0xAF,0xAA,0xFA,0x50,0x55,0xA5, first 2 cycles after first input, one per cycle, correct cero/paridad (e.g. 0x05 -> paridad=0, 0xAF -> paridad=0, 0xA5 -> paridad=0, 0x5A -> paridad=0; A=0x01 pass -> paridad=1).
2. Accumulate: PASS A=0xF0, then XOR A=0xFF acumular=1, then AND A=0x3C acumular=1 -> results 0xF0, 0x0F, 0x0C in order; XOR A=0x0C acumular=1 next -> 0x00 with salida_cero=1.
3. Backpressure: stream 5 beats with salida_listo held 0 for 4 cycles after first salida_valido -> entrada_listo falls after 2 beats buffered, salida stable, all 5 results delivered in order once listo returns, none lost or duplicated.
4. Random valid/ready toggling, 1000 beats, random opcodes and acumular -> output sequence matches reference model exactly.
5. Assert reset_n=0 asynchronously mid-stream with both stages full -> salida_valido=0 and salida=0 immediately. After release, first new beat using acumular=1 sees accumulator=0.
6. With UNIDAD_LOGICA_CONTADOR_EN and ANCHO_CONT=4: 20 output transfers -> contador_ops=15 (saturated). Without macro, contador_ops=0 throughout.
